// File: rtl/cpu_controller.sv
// Multi-cycle CPU control FSM: fetch/decode/execute/mem/writeback with a bounded
// memDone wait that parks the machine in a sticky FAULT state on timeout.
module cpu_controller #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  opcode,
    input  logic [3:0]  immediate,
    input  logic        memDone,
    input  logic        BEQ,
    output logic        read,
    output logic        write,
    output logic        instruction,
    output logic        instructionType,
    output logic [2:0]  ALU_Op,
    output logic        writeFlag,
    output logic [12:0] PC,
    output logic        fault,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'b000,
        S_DECODE    = 3'b001,
        S_EXECUTE   = 3'b010,
        S_MEM       = 3'b011,
        S_WRITEBACK = 3'b100,
        S_FAULT     = 3'b101
    } state_t;

    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_LD   = 3'b101;
    localparam logic [2:0] OP_ST   = 3'b110;
    localparam logic [2:0] OP_BEQ  = 3'b111;
    localparam logic [3:0] TMO     = 4'(TIMEOUT);

    state_t      r_state;
    logic        r_run;
    logic [2:0]  r_op;
    logic [3:0]  r_imm;
    logic [12:0] r_pc;
    logic [2:0]  r_alu;
    logic [3:0]  r_wait;

    state_t      w_next_state;
    logic [12:0] w_next_pc;
    logic [3:0]  w_next_wait;
    logic [3:0]  w_wait_inc;
    logic [12:0] w_offset;

    function automatic logic [2:0] alu_map(input logic [2:0] op);
        case (op)
            OP_SUB, OP_BEQ: alu_map = 3'b001;
            OP_AND:         alu_map = 3'b010;
            OP_OR:          alu_map = 3'b011;
            default:        alu_map = 3'b000;
        endcase
    endfunction

    function automatic logic is_imm_op(input logic [2:0] op);
        is_imm_op = (op == OP_ADDI) || (op == OP_LD) || (op == OP_ST);
    endfunction

    // Memory handshake: read/write is held until memDone is sampled high at a
    // rising edge in FETCH or MEM; that edge completes the access.
    // r_run is low for the first edge after reset so strobes rise on that edge
    // and memDone is only counted once a strobe is actually visible.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_wait  = r_wait;
        w_wait_inc   = r_wait + 4'd1;
        w_offset     = {{9{r_imm[3]}}, r_imm};
        if (r_run) begin
            case (r_state)
                S_FETCH: begin
                    if (memDone)                w_next_state = S_DECODE;
                    else if (w_wait_inc == TMO) w_next_state = S_FAULT;
                    else                        w_next_wait  = w_wait_inc;
                end
                S_DECODE: w_next_state = S_EXECUTE;
                S_EXECUTE: begin
                    if (r_op == OP_LD || r_op == OP_ST) begin
                        w_next_state = S_MEM;
                    end else if (r_op == OP_BEQ) begin
                        w_next_state = S_FETCH;
                        w_next_pc    = r_pc + 13'd1 + (BEQ ? w_offset : 13'd0);
                    end else begin
                        w_next_state = S_WRITEBACK;
                    end
                end
                S_MEM: begin
                    if (memDone) begin
                        if (r_op == OP_LD) begin
                            w_next_state = S_WRITEBACK;
                        end else begin
                            w_next_state = S_FETCH;
                            w_next_pc    = r_pc + 13'd1;
                        end
                    end else if (w_wait_inc == TMO) begin
                        w_next_state = S_FAULT;
                    end else begin
                        w_next_wait = w_wait_inc;
                    end
                end
                S_WRITEBACK: begin
                    w_next_state = S_FETCH;
                    w_next_pc    = r_pc + 13'd1;
                end
                S_FAULT: w_next_state = S_FAULT;
                default: w_next_state = S_FETCH;
            endcase
            if (w_next_state != r_state &&
                (w_next_state == S_FETCH || w_next_state == S_MEM)) begin
                w_next_wait = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_run   <= 1'b0;
            r_op    <= 3'd0;
            r_imm   <= 4'd0;
            r_pc    <= 13'd0;
            r_alu   <= 3'd0;
            r_wait  <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_run   <= 1'b1;
            r_pc    <= w_next_pc;
            r_wait  <= w_next_wait;
            if (r_run && r_state == S_DECODE) begin
                r_op  <= opcode;
                r_imm <= immediate;
                r_alu <= alu_map(opcode);
            end
        end
    end

    always_comb begin
        read            = 1'b0;
        write           = 1'b0;
        instruction     = 1'b0;
        instructionType = 1'b0;
        writeFlag       = 1'b0;
        fault           = 1'b0;
        if (r_run) begin
            case (r_state)
                S_FETCH: begin
                    read        = 1'b1;
                    instruction = 1'b1;
                end
                S_EXECUTE: instructionType = is_imm_op(r_op);
                S_MEM: begin
                    instructionType = 1'b1;
                    read            = (r_op == OP_LD);
                    write           = (r_op == OP_ST);
                end
                S_WRITEBACK: writeFlag = 1'b1;
                S_FAULT:     fault     = 1'b1;
                default: ;
            endcase
        end
    end

    assign ALU_Op = r_alu;
    assign PC     = r_pc;
    assign state  = r_state;

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, giving the maximum cycles a memory access waits for memDone; the legal range is 1-15.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; it SHALL be sampled only on the rising edge of clk.
REQ-004 opcode  input  3  opcode from the instruction decoder.
REQ-005 immediate  input  4  immediate field from the decoder, two's complement.
REQ-006 memDone  input  1  memory access-complete handshake.
REQ-007 BEQ  input  1  ALU equal/zero flag.
REQ-008 read  output  1  memory read strobe.
REQ-009 write  output  1  memory write strobe.
REQ-010 instruction  output  1  high when the memory access is an instruction fetch.
REQ-011 instructionType  output  1  1 for the immediate form (ADDI/LD/ST), else 0.
REQ-012 ALU_Op  output  3  ALU operation select.
REQ-013 writeFlag  output  1  register-file write enable.
REQ-014 PC  output  13  program counter.
REQ-015 fault  output  1  sticky memory-timeout indication.
REQ-016 state  output  3  current FSM state, for debug.

Function
REQ-017 States SHALL be encoded FETCH=000, DECODE=001, EXECUTE=010, MEM=011, WRITEBACK=100, FAULT=101; codes 110 and 111 SHALL go to FETCH on the next edge.
REQ-018 All outputs SHALL depend only on registered state, the latched opcode, PC and fault, with no combinational path from any input to any output.
REQ-019 Opcode map: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 ADDI, 101 LD, 110 ST, 111 BEQ.
REQ-020 FETCH: read=1 and instruction=1; on memDone go to DECODE, else stay.
REQ-021 DECODE: latch opcode and immediate into internal registers, then go to EXECUTE after one cycle.
REQ-022 EXECUTE (one cycle) ALU_Op SHALL be: ADD/ADDI/LD/ST=000, SUB=001, AND=010, OR=011, BEQ=001.
REQ-023 EXECUTE: instructionType SHALL be 1 for ADDI/LD/ST, else 0.
REQ-024 EXECUTE next state: LD/ST go to MEM; BEQ goes to FETCH; all other opcodes go to WRITEBACK.
REQ-025 BEQ is sampled only in EXECUTE with opcode 111: PC <= PC+1+sign_extend(immediate) if BEQ=1, else PC+1.
REQ-026 MEM: LD drives read=1, ST drives write=1, with instruction=0 and instructionType=1 in both cases.
REQ-027 MEM with memDone: LD goes to WRITEBACK; ST goes to FETCH with PC <= PC+1.
REQ-028 WRITEBACK: writeFlag=1 for exactly one cycle, PC <= PC+1, then go to FETCH.
REQ-029 PC arithmetic SHALL be modulo 2^13: 8191+1 = 0, and 0 plus an offset of -1 = 8191.
REQ-030 A 4-bit wait counter SHALL clear on entry to FETCH or MEM and increment each cycle spent there without memDone.
REQ-031 If the counter reaches TIMEOUT without memDone, the FSM SHALL go to FAULT.
REQ-032 If memDone arrives in the same cycle the counter reaches TIMEOUT, memDone SHALL win and no fault occurs.
REQ-033 FAULT: fault=1 with read, write, instruction and writeFlag all 0; PC SHALL be held; only reset exits FAULT.
REQ-034 memDone asserted in DECODE, EXECUTE, WRITEBACK or FAULT SHALL be ignored.
REQ-035 Strobes not named for the current state SHALL be 0.
REQ-036 ALU_Op SHALL hold its last value outside EXECUTE/MEM/WRITEBACK.
REQ-037 With a one-cycle memDone, instruction latency SHALL be: ALU/ADDI 4 cycles, LD 5, ST 4, BEQ 3.

Reset
REQ-038 While reset=0 at a clock edge: state=FETCH, PC=0, read=write=instruction=instructionType=writeFlag=0, ALU_Op=000, fault=0, wait counter=0, latched opcode/immediate=0.
REQ-039 Reset asserted mid-access (FETCH/MEM/FAULT) SHALL deassert all strobes at that same edge, with no completion of the pending instruction.
REQ-040 After reset is released, read=1 and instruction=1 SHALL appear at the first edge.

Verification
REQ-041 Reset released, memDone=1 every cycle, opcode=000 -> states FETCH,DECODE,EXECUTE,WRITEBACK repeat; writeFlag high 1 cycle per 4; PC = 0,1,2...
REQ-042 PC=10, opcode=111, immediate=1100, BEQ=1 in EXECUTE -> PC=7; the same with BEQ=0 -> PC=11.
REQ-043 opcode=101 with memDone delayed 3 cycles in MEM -> read=1 and instruction=0 for 4 cycles, then WRITEBACK, writeFlag pulse, PC+1.
REQ-044 TIMEOUT=15, memDone held 0 in FETCH -> FAULT after 15 cycles, fault=1 sticky; memDone=1 on cycle 15 instead -> DECODE, fault=0.
REQ-045 PC=8191 with an ADD completing -> PC=0; reset=0 asserted during MEM of an ST -> write=0 at that edge, PC=0, state=FETCH.
